coef_loader: RTL and testbench

- Upstream neighbour of the 2D IDCT stage in the MPEG2 decoder.
- Consumes (run, level, eob) symbols from the VLC/run-length decoder and de-zigzags them into raster coefficient addresses.
- Writes all 64 coefficients into the IDCT's input port (iaddr/idata/iwren), zero-filling runs and the block tail, then pulses en to start the transform.
- Owns the handshake that keeps writes away from the IDCT while it is busy.

---
 rtl/mpeg2_pkg.sv | 38 +++
 rtl/scan_rom.sv | 14 +
 rtl/coef_loader.sv | 167 ++++++++++++++++
 tb/tb_coef_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpeg2_pkg.sv
// Shared MPEG2 decoder constants: block size, loader states and scan tables.
// Tables map scan index to raster address (row*8 + col).
package mpeg2_pkg;

  localparam int NCOEF = 64;
  localparam int IDX_W = $clog2(NCOEF);

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    FILL,
    START,
    BUSY
  } state_t;

  localparam logic [IDX_W-1:0] ZZ [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [IDX_W-1:0] ALT [NCOEF] = '{
    6'd0,  6'd8,  6'd16, 6'd24, 6'd1,  6'd9,  6'd2,  6'd10,
    6'd17, 6'd25, 6'd32, 6'd40, 6'd48, 6'd56, 6'd57, 6'd49,
    6'd41, 6'd33, 6'd26, 6'd18, 6'd3,  6'd11, 6'd4,  6'd12,
    6'd19, 6'd27, 6'd34, 6'd42, 6'd50, 6'd58, 6'd35, 6'd43,
    6'd51, 6'd59, 6'd20, 6'd28, 6'd5,  6'd13, 6'd6,  6'd14,
    6'd21, 6'd29, 6'd36, 6'd44, 6'd52, 6'd60, 6'd37, 6'd45,
    6'd53, 6'd61, 6'd22, 6'd30, 6'd7,  6'd15, 6'd23, 6'd31,
    6'd38, 6'd46, 6'd54, 6'd62, 6'd39, 6'd47, 6'd55, 6'd63
  };

endpackage

// File: rtl/scan_rom.sv
// Scan index to raster address lookup, zigzag or alternate scan.
// Purely combinational; also used by the encoder bench model.
module scan_rom
  import mpeg2_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             alt,
  output logic [IDX_W-1:0] addr
);

  // table select
  assign addr = alt ? ALT[idx] : ZZ[idx];

endmodule

// File: rtl/coef_loader.sv
// De-zigzags (run, level, eob) symbols into 64 IDCT coefficient writes.
// ALT_SCAN_EN adds alt_scan to select the alternate scan per block.
module coef_loader
  import mpeg2_pkg::*;
#(
  parameter int LVL_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [IDX_W-1:0] run,
  input  logic [LVL_W-1:0] level,
  input  logic             eob,
`ifdef ALT_SCAN_EN
  input  logic             alt_scan,
`endif
  input  logic             idct_rdy,
  output logic [IDX_W-1:0] iaddr,
  output logic [LVL_W-1:0] idata,
  output logic             iwren,
  output logic             en,
  output logic             err
);

  state_t           state, state_n;
  logic [IDX_W:0]   pos, pos_n;
  logic [IDX_W-1:0] zcnt, zcnt_n;
  logic [LVL_W-1:0] lvl_q, lvl_n;
  logic             ovf_q, ovf_n;
  logic             err_n;
  logic             alt_q, alt_n;
  logic             alt_in;
  logic             wr;
  logic [LVL_W-1:0] wr_data;
  logic             en_n;
  logic [IDX_W-1:0] raddr;
  logic [IDX_W+1:0] sum;
  logic             accept;
  logic             ovf;
  logic             last;
  logic             full;

`ifdef ALT_SCAN_EN
  assign alt_in = alt_scan;
`else
  assign alt_in = 1'b0;
`endif

  assign accept = sym_valid & sym_ready;
  assign sum    = (IDX_W+2)'(pos) + (IDX_W+2)'(run);
  assign ovf    = sum > (IDX_W+2)'(NCOEF-1);
  assign last   = pos == (IDX_W+1)'(NCOEF-1);
  assign full   = pos == (IDX_W+1)'(NCOEF);

  scan_rom u_rom (
    .idx  (pos[IDX_W-1:0]),
    .alt  (alt_q),
    .addr (raddr)
  );

  // next-state, write decision and handshake
  always_comb begin
    state_n   = state;
    pos_n     = pos;
    zcnt_n    = zcnt;
    lvl_n     = lvl_q;
    ovf_n     = ovf_q;
    err_n     = err;
    alt_n     = alt_q;
    wr        = 1'b0;
    wr_data   = '0;
    en_n      = 1'b0;
    sym_ready = 1'b0;
    unique case (state)
      IDLE: begin
        sym_ready = idct_rdy;
        if (accept) begin
          if (pos == '0)
            alt_n = alt_in;
          if (eob) begin
            state_n = FILL;
          end else if (ovf) begin
            err_n   = 1'b1;
            ovf_n   = 1'b1;
            state_n = FILL;
          end else if (run != '0) begin
            zcnt_n  = run;
            lvl_n   = level;
            state_n = ZERO;
          end else begin
            wr      = 1'b1;
            wr_data = level;
            pos_n   = pos + (IDX_W+1)'(1);
            if (last)
              state_n = START;
          end
        end
      end
      ZERO: begin
        if (idct_rdy) begin
          wr    = 1'b1;
          pos_n = pos + (IDX_W+1)'(1);
          if (zcnt != '0) begin
            zcnt_n = zcnt - IDX_W'(1);
          end else begin
            wr_data = lvl_q;
            state_n = last ? START : IDLE;
          end
        end
      end
      FILL: begin
        if (full) begin
          state_n = START;
        end else if (idct_rdy) begin
          wr    = 1'b1;
          pos_n = pos + (IDX_W+1)'(1);
        end
      end
      START: begin
        en_n    = 1'b1;
        pos_n   = '0;
        ovf_n   = 1'b0;
        state_n = BUSY;
        if (!ovf_q)
          err_n = 1'b0;
      end
      BUSY: begin
        if (idct_rdy && !en)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered IDCT-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pos   <= '0;
      zcnt  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      alt_q <= 1'b0;
      err   <= 1'b0;
      en    <= 1'b0;
      iwren <= 1'b0;
      iaddr <= '0;
      idata <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      zcnt  <= zcnt_n;
      lvl_q <= lvl_n;
      ovf_q <= ovf_n;
      alt_q <= alt_n;
      err   <= err_n;
      en    <= en_n;
      iwren <= wr;
      if (wr) begin
        iaddr <= raddr;
        idata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_coef_loader.sv
// Scoreboard bench for coef_loader: directed plan plus random symbols.
// Expected writes come from a zigzag-walk model of the block.
module tb_coef_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sym_valid;
  logic       sym_ready;
  logic [5:0] run;
  logic [7:0] level;
  logic       eob;
  logic       idct_rdy;
  logic [5:0] iaddr;
  logic [7:0] idata;
  logic       iwren;
  logic       en;
  logic       err;

  typedef struct packed {
    logic       is_en;
    logic [5:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   fails = 0;
  int   zz[64];
  int   mpos = 0;
  bit   m_err = 0;
  int   busy = 0;
  bit   glitch = 0;

  always #5 clk = ~clk;

  coef_loader dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .run       (run),
    .level     (level),
    .eob       (eob),
    .idct_rdy  (idct_rdy),
    .iaddr     (iaddr),
    .idata     (idata),
    .iwren     (iwren),
    .en        (en),
    .err       (err)
  );

  // IDCT model: busy for a while after en, optional idle glitches
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idct_rdy <= 1'b0;
      busy     <= 0;
    end else if (en) begin
      idct_rdy <= 1'b0;
      busy     <= $urandom_range(2, 12);
    end else if (busy > 0) begin
      busy     <= busy - 1;
      idct_rdy <= (busy == 1);
    end else begin
      idct_rdy <= glitch ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
  end

  function automatic void build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin
          zz[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = hi; r >= lo; r--) begin
          zz[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  endfunction

  function automatic void push_w(input logic [7:0] d);
    exp_t e;
    e.is_en = 1'b0;
    e.addr  = 6'(zz[mpos]);
    e.data  = d;
    e.err   = m_err;
    q.push_back(e);
    mpos++;
  endfunction

  function automatic void push_en(input bit ovf);
    exp_t e;
    e.is_en = 1'b1;
    e.addr  = '0;
    e.data  = '0;
    e.err   = ovf;
    q.push_back(e);
    m_err = ovf;
    mpos  = 0;
  endfunction

  // reference model: the block as 64 scan slots
  function automatic void model_sym(input int r, input logic [7:0] l,
                                    input bit e);
    if (e) begin
      while (mpos < 64) push_w(8'h00);
      push_en(0);
    end else if (mpos + r > 63) begin
      m_err = 1;
      while (mpos < 64) push_w(8'h00);
      push_en(1);
    end else begin
      repeat (r) push_w(8'h00);
      push_w(l);
      if (mpos == 64) push_en(0);
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor: pop and compare on every write or start pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sym_ready === 1'b1 && idct_rdy !== 1'b1)
        chk("sym_ready_while_busy", 1, 0);
      if (iwren === 1'b1 || en === 1'b1) begin
        exp_t e;
        if (iwren === 1'b1 && en === 1'b1)
          chk("wr_and_en_together", 1, 0);
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          vecs++;
          if (e.is_en != en || (iwren && (iaddr != e.addr ||
              idata != e.data)) || err != e.err) begin
            fails++;
            $display("FAIL %s: got en=%0d a=%0d d=%h err=%0d expected en=%0d a=%0d d=%h err=%0d",
                     e.is_en ? "start" : "write", en, iaddr, idata, err,
                     e.is_en, e.addr, e.data, e.err);
          end
        end
      end
    end
  end

  // issue one symbol; caller sits at posedge+1
  task automatic send(input int r, input logic [7:0] l, input bit e);
    int n = 0;
    sym_valid = 1'b1;
    run       = 6'(r);
    level     = l;
    eob       = e;
    while (sym_ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      chk("sym_ready_timeout", n, 0);
      sym_valid = 1'b0;
    end else begin
      model_sym(r, l, e);
      @(posedge clk);
      #1;
      sym_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    build_zz();
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    run       = '0;
    level     = '0;
    eob       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_iwren", iwren, 0);
    chk("rst_en", en, 0);
    chk("rst_err", err, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_idata", idata, 0);
    chk("rst_sym_ready", sym_ready, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(0, 8'h00, 1);
    drain();
    send(0, 8'h05, 0);
    send(0, 8'h00, 1);
    send(1, 8'hFD, 0);
    send(2, 8'h07, 0);
    send(0, 8'h00, 1);
    for (int i = 0; i < 64; i++) send(0, 8'h01, 0);
    send(0, 8'h00, 1);
    for (int i = 0; i < 60; i++) send(0, 8'($urandom), 0);
    send(10, 8'h04, 0);
    send(3, 8'h22, 0);
    send(0, 8'h00, 1);
    send(0, 8'h00, 1);
    drain();

    for (int i = 0; i < 20; i++) send(0, 8'($urandom), 0);
    send(50, 8'h11, 0);
    send(20, 8'h33, 0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_iwren", iwren, 0);
    chk("midrst_en", en, 0);
    chk("midrst_err", err, 0);
    q.delete();
    mpos  = 0;
    m_err = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0, 8'h09, 0);
    send(0, 8'h00, 1);
    drain();

    glitch = 1;
    for (int i = 0; i < 500; i++) begin
      int r;
      bit e;
      e = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 1) == 0) ? 0 :
          (($urandom_range(0, 7) == 0) ? $urandom_range(0, 63)
                                       : $urandom_range(1, 6));
      send(r, 8'($urandom), e);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
    end
    send(0, 8'h00, 1);
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("final_queue", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
